// File: rtl/ni_pkg.sv
// ni_pkg: packet field layout, field extract helpers and injection FSM states for pe_net_iface.
package ni_pkg;
    localparam int DEST_Y_OFF = 0;
    localparam int DEST_X_OFF = 2;
    localparam int SRC_Y_OFF  = 4;
    localparam int SRC_X_OFF  = 6;
    localparam int DATA_OFF   = 8;

    typedef enum logic {IDLE, SEND} ni_state_t;

    function automatic logic [63:0] pkt_dest(input logic [63:0] pkt, input int xs, input int ys);
        return pkt & ((64'd1 << (xs + ys)) - 64'd1);
    endfunction

    function automatic logic [63:0] pkt_src(input logic [63:0] pkt, input int xs, input int ys);
        return (pkt >> (xs + ys)) & ((64'd1 << (xs + ys)) - 64'd1);
    endfunction

    function automatic logic [63:0] pkt_data(input logic [63:0] pkt, input int xs, input int ys);
        return pkt >> (2 * (xs + ys));
    endfunction
endpackage

// File: rtl/ni_sync_fifo.sv
// ni_sync_fifo: count-based synchronous FIFO; full/empty come from the registered count only.
module ni_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [AW:0]           r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = r_cnt == (AW+1)'(FIFO_DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/pe_net_iface.sv
// pe_net_iface: neuron PE <-> mesh switch network interface (multicast injection, 1-entry ejection).
// Define NI_PKT_CNT_EN to add the o_tx_cnt/o_rx_cnt packet counters.
module pe_net_iface
    import ni_pkg::*;
#(
    parameter int X_COORD     = 3,
    parameter int Y_COORD     = 1,
    parameter int X_SIZE      = 2,
    parameter int Y_SIZE      = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int TOTAL_WIDTH = 2*X_SIZE + 2*Y_SIZE + DATA_WIDTH,
    parameter int FIFO_DEPTH  = 4,
    parameter int NUM_DEST    = 4,
    parameter logic [NUM_DEST*(X_SIZE+Y_SIZE)-1:0] DEST_LIST = 16'hEA62
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_nrn_valid,
    input  logic [DATA_WIDTH-1:0]    i_nrn_data,
    output logic                     o_nrn_ready,
    output logic                     o_sw_valid,
    output logic [TOTAL_WIDTH-1:0]   o_sw_data,
    input  logic                     i_sw_ready,
    input  logic                     i_sw_valid,
    input  logic [TOTAL_WIDTH-1:0]   i_sw_data,
    output logic                     o_sw_ready,
    output logic                     o_nrn_valid,
    output logic [DATA_WIDTH-1:0]    o_nrn_data,
    output logic [X_SIZE+Y_SIZE-1:0] o_nrn_src,
    input  logic                     i_nrn_ready
`ifdef NI_PKT_CNT_EN
    ,
    output logic [15:0]              o_tx_cnt,
    output logic [15:0]              o_rx_cnt
`endif
);
    localparam int CW = X_SIZE + Y_SIZE;
    localparam int IW = NUM_DEST > 1 ? $clog2(NUM_DEST) : 1;

    ni_state_t             r_state;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_pop;
    logic                  w_cap;

    ni_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_nrn_valid),
        .i_data  (i_nrn_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Switch-facing outputs are decoded purely from registers; i_sw_ready never reaches them.
    assign o_nrn_ready = ~w_full;
    assign o_sw_valid  = r_state == SEND;
    assign o_sw_data   = {r_hold, X_SIZE'(X_COORD), Y_SIZE'(Y_COORD), DEST_LIST[r_idx*CW +: CW]};
    assign w_xfer      = o_sw_valid & i_sw_ready;
    assign w_last      = r_idx == IW'(NUM_DEST - 1);
    assign w_pop       = ~w_empty & ((r_state == IDLE) | (w_xfer & w_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else if (w_pop) begin
            r_state <= SEND;
            r_idx   <= '0;
        end else if (w_xfer) begin
            if (w_last) r_state <= IDLE;
            else r_idx <= r_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) r_hold <= w_fifo_data;
    end

    assign o_sw_ready = ~o_nrn_valid | i_nrn_ready;
    assign w_cap      = i_sw_valid & o_sw_ready;

    always_ff @(posedge clk) begin
        if (rst) o_nrn_valid <= 1'b0;
        else if (w_cap) o_nrn_valid <= 1'b1;
        else if (i_nrn_ready) o_nrn_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            o_nrn_data <= DATA_WIDTH'(pkt_data(64'(i_sw_data), X_SIZE, Y_SIZE));
            o_nrn_src  <= CW'(pkt_src(64'(i_sw_data), X_SIZE, Y_SIZE));
        end
    end

`ifdef NI_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx_cnt <= '0;
            o_rx_cnt <= '0;
        end else begin
            if (w_xfer) o_tx_cnt <= o_tx_cnt + 16'd1;
            if (w_cap) o_rx_cnt <= o_rx_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pe_net_iface.sv
// tb_pe_net_iface: directed vectors with immediate assertions for pe_net_iface.
module tb_pe_net_iface;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_nrn_valid;
    logic [7:0]  i_nrn_data;
    logic        o_nrn_ready;
    logic        o_sw_valid;
    logic [15:0] o_sw_data;
    logic        i_sw_ready;
    logic        i_sw_valid;
    logic [15:0] i_sw_data;
    logic        o_sw_ready;
    logic        o_nrn_valid;
    logic [7:0]  o_nrn_data;
    logic [3:0]  o_nrn_src;
    logic        i_nrn_ready;
`ifdef NI_PKT_CNT_EN
    logic [15:0] o_tx_cnt;
    logic [15:0] o_rx_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Own coordinates (1,3) give source nibble 4'h7 in the injected packets.
    pe_net_iface #(.X_COORD(1), .Y_COORD(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_nrn_valid (i_nrn_valid),
        .i_nrn_data  (i_nrn_data),
        .o_nrn_ready (o_nrn_ready),
        .o_sw_valid  (o_sw_valid),
        .o_sw_data   (o_sw_data),
        .i_sw_ready  (i_sw_ready),
        .i_sw_valid  (i_sw_valid),
        .i_sw_data   (i_sw_data),
        .o_sw_ready  (o_sw_ready),
        .o_nrn_valid (o_nrn_valid),
        .o_nrn_data  (o_nrn_data),
        .o_nrn_src   (o_nrn_src),
        .i_nrn_ready (i_nrn_ready)
`ifdef NI_PKT_CNT_EN
        ,
        .o_tx_cnt    (o_tx_cnt),
        .o_rx_cnt    (o_rx_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] vals [5];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
        rst = 1'b1; i_nrn_valid = 1'b0; i_nrn_data = '0; i_sw_ready = 1'b0;
        i_sw_valid = 1'b0; i_sw_data = '0; i_nrn_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_sw_valid", 32'(o_sw_valid), 32'h0);
        chk("rst_nrn_valid", 32'(o_nrn_valid), 32'h0);
        chk("rst_nrn_ready", 32'(o_nrn_ready), 32'h1);
        chk("rst_sw_ready", 32'(o_sw_ready), 32'h1);

        // single value, four destinations back to back
        i_sw_ready = 1'b1; i_nrn_valid = 1'b1; i_nrn_data = 8'h5A;
        step();
        i_nrn_valid = 1'b0;
        chk("t1_lat1_valid", 32'(o_sw_valid), 32'h0);
        step();
        chk("t1_valid", 32'(o_sw_valid), 32'h1);
        chk("t1_pkt0", 32'(o_sw_data), 32'h5A72);
        step(); chk("t1_pkt1", 32'(o_sw_data), 32'h5A76);
        step(); chk("t1_pkt2", 32'(o_sw_data), 32'h5A7A);
        step(); chk("t1_pkt3", 32'(o_sw_data), 32'h5A7E);
        step(); chk("t1_idle", 32'(o_sw_valid), 32'h0);

        // backpressure during destination 1
        i_nrn_valid = 1'b1; i_nrn_data = 8'h33;
        step();
        i_nrn_valid = 1'b0;
        step(); chk("t2_pkt0", 32'(o_sw_data), 32'h3372);
        step(); chk("t2_pkt1", 32'(o_sw_data), 32'h3376);
        i_sw_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_hold_valid", 32'(o_sw_valid), 32'h1);
            chk("t2_hold_data", 32'(o_sw_data), 32'h3376);
        end
        i_sw_ready = 1'b1;
        step(); chk("t2_pkt2", 32'(o_sw_data), 32'h337A);
        step(); chk("t2_pkt3", 32'(o_sw_data), 32'h337E);
        step(); chk("t2_idle", 32'(o_sw_valid), 32'h0);

        // fill FIFO plus hold register while the switch stalls
        i_sw_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_nrn_valid = 1'b1; i_nrn_data = vals[i];
            chk("t3_ready_before_push", 32'(o_nrn_ready), 32'h1);
            step();
        end
        i_nrn_valid = 1'b0;
        chk("t3_full", 32'(o_nrn_ready), 32'h0);
        chk("t3_head", 32'(o_sw_data), 32'h1172);
        i_sw_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                chk("t3_valid", 32'(o_sw_valid), 32'h1);
                chk("t3_pkt", 32'(o_sw_data), {16'h0, vals[i], 4'h7, 4'(2 + 4*j)});
                step();
            end
        end
        chk("t3_idle", 32'(o_sw_valid), 32'h0);
        chk("t3_ready_after", 32'(o_nrn_ready), 32'h1);

        // ejection with a stalled neuron, then capture+consume in one cycle
        i_nrn_ready = 1'b0; i_sw_valid = 1'b1; i_sw_data = 16'hC3B1;
        step();
        for (int i = 0; i < 2; i++) begin
            chk("t4_nrn_valid", 32'(o_nrn_valid), 32'h1);
            chk("t4_nrn_data", 32'(o_nrn_data), 32'hC3);
            chk("t4_nrn_src", 32'(o_nrn_src), 32'hB);
            chk("t4_sw_ready", 32'(o_sw_ready), 32'h0);
            step();
        end
        i_nrn_ready = 1'b1; i_sw_data = 16'h7E45;
        #1 chk("t4_sw_ready_rel", 32'(o_sw_ready), 32'h1);
        step();
        chk("t4_thru_data", 32'(o_nrn_data), 32'h7E);
        chk("t4_thru_src", 32'(o_nrn_src), 32'h4);
        chk("t4_thru_valid", 32'(o_nrn_valid), 32'h1);
        i_sw_valid = 1'b0;
        step(); chk("t4_drained", 32'(o_nrn_valid), 32'h0);

        // reset mid-SEND at idx 2 with another value queued
        i_nrn_valid = 1'b1; i_nrn_data = 8'h99;
        step();
        i_nrn_data = 8'hAA;
        step();
        i_nrn_valid = 1'b0;
        chk("t5_pkt0", 32'(o_sw_data), 32'h9972);
        step(); step();
        chk("t5_pkt2", 32'(o_sw_data), 32'h997A);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_sw_valid", 32'(o_sw_valid), 32'h0);
        chk("t5_nrn_ready", 32'(o_nrn_ready), 32'h1);
        step(); step();
        chk("t5_discarded", 32'(o_sw_valid), 32'h0);

`ifdef NI_PKT_CNT_EN
        chk("t6_tx_rst", 32'(o_tx_cnt), 32'h0);
        chk("t6_rx_rst", 32'(o_rx_cnt), 32'h0);
        for (int i = 0; i < 3; i++) begin
            i_nrn_valid = 1'b1; i_nrn_data = vals[i];
            step();
        end
        i_nrn_valid = 1'b0;
        for (int i = 0; i < 16; i++) step();
        chk("t6_tx_cnt", 32'(o_tx_cnt), 32'd12);
        i_sw_valid = 1'b1; i_sw_data = 16'h0102;
        step();
        i_sw_valid = 1'b0;
        chk("t6_rx_cnt", 32'(o_rx_cnt), 32'd1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
